// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared widths, FSM encoding and address helper for the memory-stage SRAM controller.
package mem_stage_sram_ctrl_pkg;

  localparam int LEN_REGISTER = 32;
  localparam int SRAM_ADDR_W  = 18;
  localparam int SRAM_DATA_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Word index inside the SRAM window: byte offset from the base, word aligned, wrapping at 512 KiB.
  function automatic logic [SRAM_ADDR_W-2:0] word_index(input logic [LEN_REGISTER-1:0] addr,
                                                        input logic [LEN_REGISTER-1:0] base);
    logic [LEN_REGISTER-1:0] off;
    off = addr - base;
    return off[SRAM_ADDR_W:2];
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_wait_counter.sv
// Wait-state counter for one SRAM half-access; flags the terminal count SRAM_WAIT-1.
module sram_wait_counter #(
  parameter int CNT_W     = 4,
  parameter int SRAM_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o,
  output logic tc_next_o
);

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(SRAM_WAIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // tc_next_o lets the controller register strobes that depend on the count one cycle ahead.
  assign tc_o      = (cnt_q == TERMINAL);
  assign tc_next_o = (cnt_d == TERMINAL);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: splits each 32-bit load/store into two 16-bit asynchronous SRAM accesses.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int                      SRAM_WAIT = 2,
  parameter logic [LEN_REGISTER-1:0] BASE_ADDR = 32'd1024,
  parameter int                      CNT_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [LEN_REGISTER-1:0] address,
  input  logic [LEN_REGISTER-1:0] write_data,
  output logic                    ready,
  output logic [LEN_REGISTER-1:0] read_data,
  output logic [SRAM_ADDR_W-1:0]  sram_addr,
  output logic [SRAM_DATA_W-1:0]  sram_dq_out,
  output logic                    sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0]  sram_dq_in,
  output logic                    sram_we_n,
  output logic                    sram_oe_n
);

  state_e                  state_q, state_d;
  logic                    isWrite_q;
  logic [SRAM_ADDR_W-2:0]  wordAddr_q;
  logic [LEN_REGISTER-1:0] wrData_q;
  logic [LEN_REGISTER-1:0] readData_q, readData_d;
  logic [SRAM_ADDR_W-1:0]  sramAddr_q, sramAddr_d;
  logic [SRAM_DATA_W-1:0]  dqOut_q, dqOut_d;
  logic                    dqOe_q, dqOe_d;
  logic                    weN_q, weN_d;
  logic                    oeN_q, oeN_d;

  logic                    req;
  logic                    accept;
  logic                    cntClr, cntEn, cntTc, cntTcNext;
  logic [SRAM_ADDR_W-2:0]  srcWord;
  logic [LEN_REGISTER-1:0] srcData;
  logic                    srcWrite;

  sram_wait_counter #(
    .CNT_W    (CNT_W),
    .SRAM_WAIT(SRAM_WAIT)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cntClr),
    .en_i     (cntEn),
    .tc_o     (cntTc),
    .tc_next_o(cntTcNext)
  );

  assign req    = mem_read | mem_write;
  assign accept = (state_q == IDLE) && req;
  assign ready  = ((state_q == IDLE) && !req) || (state_q == DONE);

  // On the accepting edge the request still comes straight from the inputs; afterwards from the latched copy.
  always_comb begin
    srcWord  = (state_q == IDLE) ? word_index(address, BASE_ADDR) : wordAddr_q;
    srcData  = (state_q == IDLE) ? write_data : wrData_q;
    srcWrite = (state_q == IDLE) ? mem_write : isWrite_q;
  end

  always_comb begin
    state_d = state_q;
    cntClr  = 1'b0;
    cntEn   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LO;
          cntClr  = 1'b1;
        end
      end
      LO: begin
        if (cntTc) begin
          state_d = HI;
          cntClr  = 1'b1;
        end else begin
          cntEn = 1'b1;
        end
      end
      HI: begin
        if (cntTc) begin
          state_d = DONE;
          cntClr  = 1'b1;
        end else begin
          cntEn = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cntClr  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cntClr  = 1'b1;
      end
    endcase
  end

  // Bus outputs are computed for the state being entered so every SRAM strobe comes from a flop.
  always_comb begin
    sramAddr_d = '0;
    dqOut_d    = '0;
    dqOe_d     = 1'b0;
    weN_d      = 1'b1;
    oeN_d      = 1'b1;
    if ((state_d == LO) || (state_d == HI)) begin
      sramAddr_d = {srcWord, (state_d == HI)};
      if (srcWrite) begin
        dqOe_d  = 1'b1;
        dqOut_d = (state_d == HI) ? srcData[31:16] : srcData[15:0];
        weN_d   = cntTcNext;
      end else begin
        oeN_d = 1'b0;
      end
    end
  end

  always_comb begin
    readData_d = readData_q;
    if (!isWrite_q && cntTc) begin
      if (state_q == LO) begin
        readData_d[15:0] = sram_dq_in;
      end else if (state_q == HI) begin
        readData_d[31:16] = sram_dq_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      isWrite_q  <= 1'b0;
      wordAddr_q <= '0;
      wrData_q   <= '0;
      readData_q <= '0;
      sramAddr_q <= '0;
      dqOut_q    <= '0;
      dqOe_q     <= 1'b0;
      weN_q      <= 1'b1;
      oeN_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      readData_q <= readData_d;
      sramAddr_q <= sramAddr_d;
      dqOut_q    <= dqOut_d;
      dqOe_q     <= dqOe_d;
      weN_q      <= weN_d;
      oeN_q      <= oeN_d;
      if (accept) begin
        isWrite_q  <= mem_write;
        wordAddr_q <= srcWord;
        wrData_q   <= write_data;
      end
    end
  end

  assign read_data   = readData_q;
  assign sram_addr   = sramAddr_q;
  assign sram_dq_out = dqOut_q;
  assign sram_dq_oe  = dqOe_q;
  assign sram_we_n   = weN_q;
  assign sram_oe_n   = oeN_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench: SRAM array model plus word-level reference memory, directed and random accesses.
module tb_mem_stage_sram_ctrl;

  localparam int          SRAM_WAIT = 2;
  localparam logic [31:0] BASE_ADDR = 32'd1024;
  localparam int          CNT_W     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        ready;
  logic [31:0] read_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
  logic        sram_oe_n;

  int checks = 0;
  int errors = 0;

  logic [15:0] sramMem [0:262143];
  logic [31:0] refMem [int];
  logic [31:0] refReadData;

  mem_stage_sram_ctrl #(
    .SRAM_WAIT(SRAM_WAIT),
    .BASE_ADDR(BASE_ADDR),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .address    (address),
    .write_data (write_data),
    .ready      (ready),
    .read_data  (read_data),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: reads follow the address while output-enabled, writes land while the strobe is low.
  assign sram_dq_in = sram_oe_n ? 16'h0000 : sramMem[sram_addr];

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sramMem[sram_addr] <= sram_dq_out;
  end

  function automatic int wordIdx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return int'((off >> 2) & 32'h0001_FFFF);
  endfunction

  function automatic logic [31:0] refLoad(input int w);
    return refMem.exists(w) ? refMem[w] : 32'h0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One complete access: drive just after the edge that enters IDLE, then sample until the DONE cycle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data);
    int          w, lowCycles, n, weLow, oeLow, clash;
    logic [17:0] loAddr, hiAddr;
    logic [15:0] loDq, hiDq;
    logic [31:0] word;
    logic        done;
    w = wordIdx(addr);
    n = 0; weLow = 0; oeLow = 0; clash = 0;
    loAddr = '1; hiAddr = '1; loDq = '0; hiDq = '0;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; address = addr; write_data = data;
    #2;
    checkOutput("ready_drops_on_request", {31'h0, ready}, 32'h0);
    lowCycles = 1;
    done = 1'b0;
    while (!done) begin
      @(posedge clk); #3;
      if (ready) begin
        done = 1'b1;
      end else begin
        if (n == 0) begin loAddr = sram_addr; loDq = sram_dq_out; end
        if (n == SRAM_WAIT) begin hiAddr = sram_addr; hiDq = sram_dq_out; end
        if (!sram_we_n) weLow++;
        if (!sram_oe_n) oeLow++;
        if (!sram_oe_n && sram_dq_oe) clash++;
        n++;
        lowCycles++;
        if (lowCycles > 4 * SRAM_WAIT + 8) begin
          checks++;
          errors++;
          $error("[TB] FAIL ready_timeout: observed ready low for %0d cycles, expected %0d", lowCycles, 1 + 2 * SRAM_WAIT);
          done = 1'b1;
        end
      end
    end
    checkOutput("latency", lowCycles, 1 + 2 * SRAM_WAIT);
    checkOutput("lo_sram_addr", {14'h0, loAddr}, 2 * w);
    checkOutput("hi_sram_addr", {14'h0, hiAddr}, 2 * w + 1);
    if (wr) begin
      refMem[w] = data;
      word = refLoad(w);
      checkOutput("store_we_low_cycles", weLow, 2 * (SRAM_WAIT - 1));
      checkOutput("store_oe_n_low_cycles", oeLow, 0);
      checkOutput("store_lo_dq", {16'h0, loDq}, {16'h0, data[15:0]});
      checkOutput("store_hi_dq", {16'h0, hiDq}, {16'h0, data[31:16]});
      checkOutput("sram_lo_half", {16'h0, sramMem[2 * w]}, {16'h0, word[15:0]});
      checkOutput("sram_hi_half", {16'h0, sramMem[2 * w + 1]}, {16'h0, word[31:16]});
    end else begin
      refReadData = refLoad(w);
      checkOutput("load_we_low_cycles", weLow, 0);
      checkOutput("load_oe_n_low_cycles", oeLow, 2 * SRAM_WAIT);
    end
    checkOutput("read_data", read_data, refReadData);
    checkOutput("dq_oe_oe_n_clash", clash, 0);
    checkOutput("done_bus_idle", {11'h0, sram_addr, sram_we_n, sram_oe_n, sram_dq_oe},
                {11'h0, 18'h0, 1'b1, 1'b1, 1'b0});
  endtask

  task automatic idleFor(input int k);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #3;
      checkOutput("idle_ready", {31'h0, ready}, 32'h1);
      checkOutput("idle_bus", {29'h0, sram_we_n, sram_oe_n, sram_dq_oe}, {29'h0, 3'b110});
    end
  endtask

  initial begin
    int          kind;
    int          w;
    logic        rd, wr;
    logic [31:0] a, d;

    for (int i = 0; i < 262144; i++) sramMem[i] = 16'h0000;
    refReadData = 32'h0;
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; address = 32'h0; write_data = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #3;
      checkOutput("reset_ready", {31'h0, ready}, 32'h1);
      checkOutput("reset_strobes", {29'h0, sram_we_n, sram_oe_n, sram_dq_oe}, {29'h0, 3'b110});
      checkOutput("reset_read_data", read_data, 32'h0);
      checkOutput("reset_sram_addr", {14'h0, sram_addr}, 32'h0);
    end

    $display("[TB] store/load round trip");
    applyStimulus(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF);
    idleFor(1);
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);
    checkOutput("round_trip_value", read_data, 32'hDEAD_BEEF);

    $display("[TB] back-to-back loads");
    idleFor(1);
    applyStimulus(1'b0, 1'b1, 32'd1024, 32'hCAFE_F00D);
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);
    checkOutput("b2b_second_value", read_data, 32'hDEAD_BEEF);

    $display("[TB] simultaneous read and write");
    applyStimulus(1'b1, 1'b1, 32'd1032, 32'h1234_5678);
    checkOutput("both_read_data_unchanged", read_data, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0);
    checkOutput("both_store_landed", read_data, 32'h1234_5678);

    $display("[TB] reset during HI phase of a store");
    idleFor(1);
    a = BASE_ADDR + 32'h4000;
    w = wordIdx(a);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b1; address = a; write_data = 32'h1234_5678;
    repeat (1 + SRAM_WAIT) @(posedge clk);
    #2;
    checkOutput("abort_in_hi_phase", {14'h0, sram_addr}, 2 * w + 1);
    rst = 1'b1;
    mem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    refReadData = 32'h0;
    checkOutput("abort_ready", {31'h0, ready}, 32'h1);
    checkOutput("abort_strobes", {29'h0, sram_we_n, sram_oe_n, sram_dq_oe}, {29'h0, 3'b110});
    checkOutput("abort_sram_addr", {14'h0, sram_addr}, 32'h0);
    checkOutput("abort_read_data", read_data, 32'h0);
    checkOutput("abort_lo_half_kept", {16'h0, sramMem[2 * w]}, 32'h0000_5678);

    $display("[TB] address wrap and alignment");
    applyStimulus(1'b0, 1'b1, BASE_ADDR + 32'h0008_0003, 32'h0BAD_CAFE);
    checkOutput("wrap_word0_lo", {16'h0, sramMem[0]}, 32'h0000_CAFE);
    checkOutput("wrap_word0_hi", {16'h0, sramMem[1]}, 32'h0000_0BAD);
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0);
    checkOutput("wrap_readback", read_data, 32'h0BAD_CAFE);

    $display("[TB] random accesses");
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      rd   = (kind != 1);
      wr   = (kind == 1) || (kind == 2);
      a    = BASE_ADDR + ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = a + ($urandom << 19);
      d    = $urandom;
      applyStimulus(rd, wr, a, d);
      if ($urandom_range(0, 1) == 1) idleFor(int'($urandom_range(1, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
